sm_mmio_timer: RTL and testbench
================================

// Module: sm_mmio_timer
// PURPOSE
//  Memory-mapped timer/compare peripheral; the responder (slave) side of the CPU data-memory bus.
//  Decodes CPU data-bus accesses in its address window; read data returns in the same cycle.
//  Counts prescaled clock ticks and raises a level interrupt on compare match.
//  irq connects to a CPU external-interrupt input (cp0_ExcIP bit).
// PARAMETERS
//  BASE_ADDR  32'h0000_0100  byte base address of the 16-byte register window; bits [3:0] must be 0
//  CNT_W      32             COUNT/CMP width, 1..32; registers read zero-extended to 32 bits
// PORTS
//  clk      in   1   clock; all state changes on posedge
//  rst_n    in   1   asynchronous active-low reset
//  bAddr    in   32  CPU data address (byte address)
//  bWe      in   1   write enable, single-cycle strobe
//  bWData   in   32  write data
//  bRData   out  32  read data, combinational
//  irq      out  1   interrupt request, level, active-high, registered
// BEHAVIOUR
//  Decode:
//  - hit = (bAddr[31:4] == BASE_ADDR[31:4]); register index = bAddr[3:2]; bAddr[1:0] ignored.
//  - Register map: 0 CTRL, 1 COUNT, 2 CMP, 3 STATUS.
//  - Read: bRData = selected register if hit, else 32'h0. A read has no side effects.
//  - Write: takes effect at the posedge where bWe & hit. bWe without hit is ignored.
//  Register fields:
//  - CTRL: [0] EN; [1] IE; [2] AUTO (reload COUNT to 0 on match); [15:8] PRESC; other bits read 0.
//  - STATUS: [0] MATCH, sticky; write 1 to clear, write 0 has no effect. Other bits read 0.
//  Reset (async, rst_n=0): CTRL=0, COUNT=0, CMP=all ones, MATCH=0, prescaler count=0, irq=0.
//  - bRData reflects the reset register contents whenever hit.
//  Prescaler:
//  - 8-bit pcnt increments each clk while EN=1.
//  - tick = EN & (pcnt == PRESC); on tick pcnt <= 0. PRESC=0 gives a tick every cycle.
//  - EN=0 holds pcnt and COUNT frozen.
//  - Any CTRL write clears pcnt to 0.
//  Counting, on tick:
//  - If COUNT == CMP: set MATCH; COUNT <= AUTO ? 0 : COUNT+1.
//  - Otherwise COUNT <= COUNT+1 modulo 2^CNT_W (all ones wraps to 0, no flag).
//  irq:
//  - irq <= MATCH_next & IE_next (registered).
//  - irq asserts the cycle after the MATCH-setting posedge, or the cycle after IE is set while MATCH=1.
//  - irq drops one cycle after MATCH is cleared or IE is cleared.
//  Simultaneous events:
//  - COUNT write in a tick cycle: the written value wins; the compare uses the pre-write COUNT.
//  - MATCH set and W1C in the same cycle: set wins; MATCH stays 1.
//  - CMP write in a tick cycle: the compare uses the old CMP.
//  - A CTRL write with EN 0->1 starts counting; the first tick is PRESC+1 cycles later.
//  Reset mid-operation: all state returns to reset values immediately, independent of clk.
// TESTING
//  Reset: rst_n=0 for 3 clk -> irq=0; read 0x100=0, 0x104=0, 0x108=FFFFFFFF, 0x10C=0.
//  Compare: CMP=5, CTRL=0x7 (EN,IE,AUTO,PRESC=0) -> COUNT 0..5.
//    MATCH set at the 6th tick; COUNT=0 after it; irq=1 the cycle after; irq stays high.
//  W1C: with MATCH=1, write STATUS=1 -> irq=0 next cycle. With AUTO the cycle repeats every 6 clk.
//    W1C coincident with a match leaves MATCH=1.
//  Prescale: CTRL=0x0301, CMP=2 -> COUNT increments every 4 clk.
//    MATCH set 12 clk after enable; irq stays 0 (IE=0); set IE -> irq=1 next cycle.
//  Wrap: CNT_W=8, COUNT=0xFE, CMP=0x10, EN -> COUNT FE,FF,00,01... with no MATCH at the wrap.
//    MATCH at COUNT=0x10.
//  Decode and collision: an access to 0x110 or 0x0FC -> no register change, bRData=0.
//    COUNT write on a tick -> the written value is kept.
//    rst_n pulse mid-count -> all registers reset asynchronously.

Source files
------------

// File: rtl/sm_mmio_timer.sv
// Memory-mapped timer/compare peripheral on the CPU data bus.
// Prescaled counter with compare match, sticky W1C status and registered level interrupt.
module sm_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bAddr,
    input  logic        bWe,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    output logic        irq
);

    logic             r_en;
    logic             r_ie;
    logic             r_auto;
    logic [7:0]       r_presc;
    logic [7:0]       r_pcnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_cmp;
    logic             r_match;
    logic             r_irq;

    logic             w_hit;
    logic [1:0]       w_idx;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_cmp;
    logic             w_wr_stat;
    logic             w_tick;
    logic             w_set;
    logic             w_w1c;
    logic             w_match_nxt;
    logic             w_ie_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [7:0]       w_pcnt_nxt;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_hit      = (bAddr[31:4] == BASE_ADDR[31:4]);
    assign w_idx      = bAddr[3:2];
    assign w_wr       = bWe & w_hit;
    assign w_wr_ctrl  = w_wr & (w_idx == 2'd0);
    assign w_wr_count = w_wr & (w_idx == 2'd1);
    assign w_wr_cmp   = w_wr & (w_idx == 2'd2);
    assign w_wr_stat  = w_wr & (w_idx == 2'd3);

    assign w_tick      = r_en & (r_pcnt == r_presc);
    // Compare sees pre-write COUNT and CMP; a set beats a coincident W1C.
    assign w_set       = w_tick & (r_count == r_cmp);
    assign w_w1c       = w_wr_stat & bWData[0];
    assign w_match_nxt = w_set | (r_match & ~w_w1c);
    assign w_ie_nxt    = w_wr_ctrl ? bWData[1] : r_ie;

    assign w_unused = &{1'b0, bAddr[1:0], bWData};

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = bWData[CNT_W-1:0];
        end else if (w_tick) begin
            if (w_set && r_auto) begin
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_wr_ctrl) begin
            w_pcnt_nxt = 8'd0;
        end else if (w_tick) begin
            w_pcnt_nxt = 8'd0;
        end else if (r_en) begin
            w_pcnt_nxt = r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_auto  <= 1'b0;
            r_presc <= 8'd0;
            r_pcnt  <= 8'd0;
            r_count <= '0;
            r_cmp   <= '1;
            r_match <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en    <= bWData[0];
                r_ie    <= bWData[1];
                r_auto  <= bWData[2];
                r_presc <= bWData[15:8];
            end
            if (w_wr_cmp) begin
                r_cmp <= bWData[CNT_W-1:0];
            end
            r_pcnt  <= w_pcnt_nxt;
            r_count <= w_count_nxt;
            r_match <= w_match_nxt;
            r_irq   <= w_match_nxt & w_ie_nxt;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_hit) begin
            case (w_idx)
                2'd0:    w_rdata = {16'h0, r_presc, 5'h0, r_auto, r_ie, r_en};
                2'd1:    w_rdata[CNT_W-1:0] = r_count;
                2'd2:    w_rdata[CNT_W-1:0] = r_cmp;
                default: w_rdata[0] = r_match;
            endcase
        end
    end

    assign bRData = w_rdata;
    assign irq    = r_irq;

endmodule

// File: tb/tb_sm_mmio_timer.sv
// Directed bench for sm_mmio_timer: one cycle-per-entry vector table on a 32-bit
// instance, plus hand sequences for async reset and an 8-bit counter wrap.
module tb_sm_mmio_timer;

    logic        clk;
    logic        rst_n;
    logic [31:0] bAddr;
    logic        bWe;
    logic [31:0] bWData;
    logic [31:0] bRData;
    logic        irq;
    logic [31:0] bAddr8;
    logic        bWe8;
    logic [31:0] bWData8;
    logic [31:0] bRData8;
    logic        irq8;

    int checks;
    int errors;

    sm_mmio_timer u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bAddr  (bAddr),
        .bWe    (bWe),
        .bWData (bWData),
        .bRData (bRData),
        .irq    (irq)
    );

    sm_mmio_timer #(.CNT_W(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bAddr  (bAddr8),
        .bWe    (bWe8),
        .bWData (bWData8),
        .bRData (bRData8),
        .irq    (irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
        bit          irq;
    } vec_t;

    vec_t vq[$];

    function automatic void rd(logic [31:0] a, logic [31:0] e, bit i);
        vec_t v;
        v = '{we: 1'b0, addr: a, wdata: 32'h0, chk: 1'b1, exp: e, irq: i};
        vq.push_back(v);
    endfunction

    function automatic void wr(logic [31:0] a, logic [31:0] d, bit i);
        vec_t v;
        v = '{we: 1'b1, addr: a, wdata: d, chk: 1'b0, exp: 32'h0, irq: i};
        vq.push_back(v);
    endfunction

    function automatic void wrc(logic [31:0] a, logic [31:0] d, logic [31:0] e, bit i);
        vec_t v;
        v = '{we: 1'b1, addr: a, wdata: d, chk: 1'b1, exp: e, irq: i};
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bAddr   = 32'h0;
        bWe     = 1'b0;
        bWData  = 32'h0;
        bAddr8  = 32'h0;
        bWe8    = 1'b0;
        bWData8 = 32'h0;

        // Reset values
        rd(32'h100, 32'h0, 0);
        rd(32'h104, 32'h0, 0);
        rd(32'h108, 32'hFFFF_FFFF, 0);
        rd(32'h10C, 32'h0, 0);
        // Compare with AUTO, PRESC=0
        wr(32'h108, 32'd5, 0);
        wr(32'h100, 32'h7, 0);
        rd(32'h104, 32'd0, 0);
        rd(32'h104, 32'd1, 0);
        rd(32'h104, 32'd2, 0);
        rd(32'h104, 32'd3, 0);
        rd(32'h104, 32'd4, 0);
        rd(32'h104, 32'd5, 0);
        rd(32'h10C, 32'd1, 1);
        rd(32'h104, 32'd1, 1);
        // W1C then the next AUTO period
        wr(32'h10C, 32'd1, 1);
        rd(32'h10C, 32'd0, 0);
        rd(32'h104, 32'd4, 0);
        rd(32'h104, 32'd5, 0);
        rd(32'h10C, 32'd1, 1);
        // W1C coincident with a match
        wr(32'h10C, 32'd1, 1);
        rd(32'h10C, 32'd0, 0);
        rd(32'h104, 32'd3, 0);
        rd(32'h104, 32'd4, 0);
        wr(32'h10C, 32'd1, 0);
        rd(32'h10C, 32'd1, 1);
        rd(32'h104, 32'd1, 1);
        // Prescale 3, IE=0
        wr(32'h100, 32'h0, 1);
        wr(32'h10C, 32'd1, 0);
        wr(32'h104, 32'd0, 0);
        wr(32'h108, 32'd2, 0);
        wr(32'h100, 32'h301, 0);
        rd(32'h100, 32'h301, 0);
        rd(32'h104, 32'd0, 0);
        rd(32'h104, 32'd0, 0);
        rd(32'h104, 32'd0, 0);
        rd(32'h104, 32'd1, 0);
        rd(32'h104, 32'd1, 0);
        rd(32'h104, 32'd1, 0);
        rd(32'h104, 32'd1, 0);
        rd(32'h104, 32'd2, 0);
        rd(32'h104, 32'd2, 0);
        rd(32'h104, 32'd2, 0);
        rd(32'h10C, 32'd0, 0);
        rd(32'h10C, 32'd1, 0);
        rd(32'h104, 32'd3, 0);
        wr(32'h100, 32'h303, 0);
        rd(32'h10C, 32'd1, 1);
        // Decode misses
        wrc(32'h110, 32'h0, 32'h0, 1);
        wrc(32'h0FC, 32'h1, 32'h0, 1);
        rd(32'h0FC, 32'h0, 1);
        rd(32'h10C, 32'd1, 1);
        rd(32'h100, 32'h303, 1);
        rd(32'h10B, 32'd2, 1);
        // COUNT write on a tick
        wr(32'h100, 32'h1, 1);
        wr(32'h104, 32'h50, 0);
        rd(32'h104, 32'h50, 0);
        rd(32'h104, 32'h51, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("irq_in_reset", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            bWe    = vq[i].we;
            bAddr  = vq[i].addr;
            bWData = vq[i].wdata;
            @(negedge clk);
            if (vq[i].chk) chk($sformatf("v%0d_rdata", i), bRData, vq[i].exp);
            chk($sformatf("v%0d_irq", i), {31'h0, irq}, {31'h0, vq[i].irq});
            @(posedge clk);
            #1;
        end
        bWe = 1'b0;

        // Asynchronous reset mid-count
        bAddr = 32'h104;
        #1;
        chk("pre_reset_count", bRData, 32'h52);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", bRData, 32'h0);
        bAddr = 32'h108;
        #1;
        chk("async_cmp", bRData, 32'hFFFF_FFFF);
        bAddr = 32'h100;
        #1;
        chk("async_ctrl", bRData, 32'h0);
        bAddr = 32'h10C;
        #1;
        chk("async_status", bRData, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        bAddr = 32'h104;
        @(negedge clk);
        chk("post_reset_frozen", bRData, 32'h0);
        @(posedge clk);
        #1;

        // 8-bit counter wrap with no match at the wrap
        bWe8 = 1'b1;
        bAddr8 = 32'h104; bWData8 = 32'hFE;
        @(posedge clk); #1;
        bAddr8 = 32'h108; bWData8 = 32'h10;
        @(posedge clk); #1;
        bAddr8 = 32'h100; bWData8 = 32'h1;
        @(posedge clk); #1;
        bWe8 = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            bAddr8 = 32'h104;
            #1;
            chk($sformatf("wrap_count_%0d", k), bRData8, (32'hFE + k) & 32'hFF);
            bAddr8 = 32'h10C;
            #1;
            chk($sformatf("wrap_status_%0d", k), bRData8, 32'h0);
        end
        @(negedge clk);
        bAddr8 = 32'h104;
        #1;
        chk("wrap_match_count", bRData8, 32'h11);
        bAddr8 = 32'h10C;
        #1;
        chk("wrap_match_status", bRData8, 32'h1);
        chk("wrap_irq_ie0", {31'h0, irq8}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
